// File: rtl/nbody_pkg.sv
// Shared definitions for the n-body step sequencer: state encoding,
// sticky error bit positions and the default object-index width.
package nbody_pkg;

  localparam int DEFAULT_ADDR_LEN = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ARM     = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int ERR_ZERO    = 0;
  localparam int ERR_BUSY    = 1;
  localparam int ERR_TIMEOUT = 2;

endpackage

// File: rtl/nbody_step_sequencer_edge_det.sv
// Registered rising-edge detector; i_prime seeds the history so a level
// that is already high when tracking begins is not mistaken for an edge.
module nbody_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_prime,
  input  logic i_track,
  input  logic i_sig,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= 1'b0;
    end else if (i_prime || i_track) begin
      r_q <= i_sig;
    end
  end

  assign o_rise = i_track & i_sig & ~r_q;

endmodule

// File: rtl/nbody_step_sequencer.sv
// Per-timestep controller between the HPS register bridge and the city engine.
// Optional watchdog enabled by defining NBODY_STEP_TIMEOUT_EN.
module nbody_step_sequencer
  import nbody_pkg::*;
#(
  parameter int              ADDR_LEN       = DEFAULT_ADDR_LEN,
  parameter int              CYC_W          = 32,
  parameter logic [CYC_W-1:0] TIMEOUT_CYCLES = CYC_W'(50_000_000)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [ADDR_LEN-1:0] i_num_objects,
  input  logic                i_hps_we,
  input  logic                i_city_done,
  input  logic                i_ack,
  output logic                o_sending,
  output logic                o_load_allow,
  output logic                o_busy,
  output logic                o_done,
  output logic [2:0]          o_err,
  output logic [CYC_W-1:0]    o_cycles,
  output logic [2:0]          o_state
);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_LEN-1:0] r_count;
  logic [ADDR_LEN-1:0] r_load_cnt;
  logic [ADDR_LEN-1:0] w_load_next;
  logic [CYC_W-1:0]    r_cycles;
  logic [2:0]          r_err;
  logic                w_done_evt;
  logic                w_timeout;
  logic                w_arm;
  logic                w_compute;

  assign w_arm       = (r_state == ST_ARM);
  assign w_compute   = (r_state == ST_COMPUTE);
  assign w_load_next = r_load_cnt + ADDR_LEN'(1);

  nbody_edge_det u_done_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_prime (w_arm),
    .i_track (w_compute),
    .i_sig   (i_city_done),
    .o_rise  (w_done_evt)
  );

`ifdef NBODY_STEP_TIMEOUT_EN
  assign w_timeout = w_compute && !w_done_evt && (r_cycles == TIMEOUT_CYCLES);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_start && (i_num_objects != '0)) w_next = ST_LOAD;
      ST_LOAD:    if (i_hps_we && (w_load_next == r_count)) w_next = ST_ARM;
      ST_ARM:     w_next = ST_COMPUTE;
      ST_COMPUTE: if (w_done_evt || w_timeout) w_next = ST_DONE;
      ST_DONE:    if (i_ack) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_sending    = 1'b0;
    o_load_allow = 1'b0;
    o_done       = 1'b0;
    o_busy       = (r_state != ST_IDLE);
    case (r_state)
      ST_LOAD:    o_load_allow = 1'b1;
      ST_COMPUTE: o_sending    = 1'b1;
      ST_DONE:    o_done       = 1'b1;
      default:    ;
    endcase
  end

  // Cycle counter stops (rather than wraps) at all-ones and is not bumped in the completing cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count    <= '0;
      r_load_cnt <= '0;
      r_cycles   <= '0;
      r_err      <= '0;
    end else begin
      if (i_start && (r_state != ST_IDLE)) r_err[ERR_BUSY] <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_num_objects == '0) begin
              r_err[ERR_ZERO] <= 1'b1;
            end else begin
              r_count    <= i_num_objects;
              r_load_cnt <= '0;
              r_err      <= '0;
            end
          end
        end
        ST_LOAD:    if (i_hps_we) r_load_cnt <= w_load_next;
        ST_ARM:     r_cycles <= '0;
        ST_COMPUTE: begin
          if (w_timeout) r_err[ERR_TIMEOUT] <= 1'b1;
          else if (!w_done_evt && (r_cycles != '1)) r_cycles <= r_cycles + CYC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_state  = r_state;
  assign o_err    = r_err;
  assign o_cycles = r_cycles;

endmodule

// File: tb/tb_nbody_step_sequencer.sv
// Self-checking bench for nbody_step_sequencer: directed steps plus randomized
// steps whose expected latencies and cycle counts come from a timeline model.
module tb_nbody_step_sequencer;

  localparam int ADDR_LEN = 12;
  localparam int CYC_W    = 32;
  localparam int TMO      = 20;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [ADDR_LEN-1:0] numObjects;
  logic                hpsWe;
  logic                cityDone;
  logic                ack;
  logic                sending;
  logic                loadAllow;
  logic                busy;
  logic                done;
  logic [2:0]          err;
  logic [CYC_W-1:0]    cycles;
  logic [2:0]          state;

  int errors = 0;
  int checks = 0;

  nbody_step_sequencer #(
    .ADDR_LEN       (ADDR_LEN),
    .CYC_W          (CYC_W),
    .TIMEOUT_CYCLES (CYC_W'(TMO))
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_num_objects (numObjects),
    .i_hps_we      (hpsWe),
    .i_city_done   (cityDone),
    .i_ack         (ack),
    .o_sending     (sending),
    .o_load_allow  (loadAllow),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .o_cycles      (cycles),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full timestep: start, n counted writes, compute for `delay` cycles until
  // the city done edge, then acknowledge. The expected cycle count is the number
  // of clock periods between entering compute and the done rising edge.
  task automatic applyStimulus(input int n, input int delay, input bit stale,
                               input bit startInLoad, input bit startWithAck, input int gapMax);
    int gap;
    int dropAt;
    cityDone   = stale;
    numObjects = ADDR_LEN'(n);
    start      = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("loadEntry.state", 32'(state), 32'd1);
    checkOutput("loadEntry.err", 32'(err), 32'd0);
    checkOutput("loadEntry.loadAllow", 32'(loadAllow), 32'd1);
    if (startInLoad) begin
      numObjects = ADDR_LEN'($urandom_range(1, 20));
      start      = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("busyStartLoad.err", 32'(err), 32'b010);
      checkOutput("busyStartLoad.state", 32'(state), 32'd1);
    end
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, gapMax);
      repeat (gap) tick();
      hpsWe = 1'b1;
      tick();
      hpsWe = 1'b0;
      if (k < n - 1) checkOutput("stillLoad.state", 32'(state), 32'd1);
    end
    checkOutput("arm.state", 32'(state), 32'd2);
    checkOutput("arm.sending", 32'(sending), 32'd0);
    checkOutput("arm.loadAllow", 32'(loadAllow), 32'd0);
    tick();
    checkOutput("compute.sending", 32'(sending), 32'd1);
    checkOutput("compute.state", 32'(state), 32'd3);
    dropAt = stale ? $urandom_range(1, delay - 1) : 0;
    for (int c = 1; c <= delay; c++) begin
      tick();
      checkOutput("noEarlyDone", 32'(done), 32'd0);
      hpsWe = 1'($urandom_range(0, 1));
      if (stale && c == dropAt) cityDone = 1'b0;
      if (c == delay) cityDone = 1'b1;
    end
    hpsWe = 1'b0;
    tick();
    checkOutput("done.flag", 32'(done), 32'd1);
    checkOutput("done.state", 32'(state), 32'd4);
    checkOutput("done.cycles", cycles, 32'(delay));
    checkOutput("done.sending", 32'(sending), 32'd0);
    checkOutput("done.busy", 32'(busy), 32'd1);
    tick();
    checkOutput("doneHold.cycles", cycles, 32'(delay));
    checkOutput("doneHold.flag", 32'(done), 32'd1);
    ack   = 1'b1;
    start = startWithAck;
    tick();
    ack   = 1'b0;
    start = 1'b0;
    checkOutput("ack.state", 32'(state), 32'd0);
    checkOutput("ack.done", 32'(done), 32'd0);
    checkOutput("ack.err", 32'(err), (startInLoad || startWithAck) ? 32'b010 : 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    numObjects = '0;
    hpsWe      = 1'b0;
    cityDone   = 1'b0;
    ack        = 1'b0;
    tick();
    tick();
    checkOutput("reset.state", 32'(state), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.sending", 32'(sending), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.err", 32'(err), 32'd0);
    checkOutput("reset.cycles", cycles, 32'd0);
    checkOutput("reset.loadAllow", 32'(loadAllow), 32'd0);
    rst = 1'b0;
    tick();

    // Zero-object request is rejected and flagged; next good start clears it.
    numObjects = '0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("zero.state", 32'(state), 32'd0);
    checkOutput("zero.err", 32'(err), 32'b001);
    checkOutput("zero.busy", 32'(busy), 32'd0);
    applyStimulus(2, 5, 1'b0, 1'b0, 1'b0, 1);

    // Directed: three back-to-back writes, done edge ten cycles into compute.
    applyStimulus(3, 10, 1'b0, 1'b0, 1'b0, 0);

    // Stale done level carried over, single object.
    applyStimulus(1, 12, 1'b1, 1'b0, 1'b0, 0);

    // Busy starts during load and alongside the acknowledge.
    applyStimulus(2, 4, 1'b0, 1'b1, 1'b1, 2);

    // Writes while idle are not counted toward the next step.
    repeat (3) begin
      hpsWe = 1'b1;
      tick();
    end
    hpsWe = 1'b0;
    checkOutput("idleWrites.state", 32'(state), 32'd0);
    applyStimulus(2, 3, 1'b0, 1'b0, 1'b0, 0);

    // Randomized steps.
    for (int s = 0; s < 8; s++) begin
      applyStimulus($urandom_range(1, 6), $urandom_range(2, 40), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3);
    end

    // Asynchronous reset in the middle of compute.
    cityDone   = 1'b0;
    numObjects = ADDR_LEN'(1);
    start      = 1'b1;
    tick();
    start = 1'b0;
    hpsWe = 1'b1;
    tick();
    hpsWe = 1'b0;
    tick();
    checkOutput("preReset.state", 32'(state), 32'd3);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncReset.state", 32'(state), 32'd0);
    checkOutput("asyncReset.busy", 32'(busy), 32'd0);
    checkOutput("asyncReset.sending", 32'(sending), 32'd0);
    checkOutput("asyncReset.done", 32'(done), 32'd0);
    checkOutput("asyncReset.cycles", cycles, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Compute with no done edge: watchdog when enabled, otherwise wait forever.
    numObjects = ADDR_LEN'(1);
    start      = 1'b1;
    tick();
    start = 1'b0;
    hpsWe = 1'b1;
    tick();
    hpsWe = 1'b0;
    tick();
`ifdef NBODY_STEP_TIMEOUT_EN
    repeat (TMO + 1) tick();
    checkOutput("timeout.state", 32'(state), 32'd4);
    checkOutput("timeout.err", 32'(err), 32'b100);
    checkOutput("timeout.cycles", cycles, 32'(TMO));
    checkOutput("timeout.done", 32'(done), 32'd1);
`else
    repeat (1000) tick();
    checkOutput("noTimeout.state", 32'(state), 32'd3);
    checkOutput("noTimeout.cycles", cycles, 32'd1000);
    checkOutput("noTimeout.err", 32'(err), 32'd0);
    cityDone = 1'b1;
    tick();
    checkOutput("lateDone.state", 32'(state), 32'd4);
    checkOutput("lateDone.cycles", cycles, 32'd1000);
`endif
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput("final.state", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
